// File: rtl/param_memory_2p.sv
// Simple-dual-port RAM: byte-enabled write port, registered read port, post-reset clear sequencer.
// Latency: read data/valid 1+OUT_REG cycles after rd_en; writes land on the sampling edge.
// Backpressure: none, one read and one write per cycle; all requests are dropped while init_busy=1.
// Ports: clk/rst_n (async active-low); wr_en/wr_addr/wr_data/wr_be write port;
//        rd_en/rd_addr read request; rd_data/rd_valid read result (data held between reads);
//        init_busy clear in progress; addr_err one-cycle strobe for any request addressed >= DEPTH.
module param_memory_2p #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int BYTE_W  = 8,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [WIDTH/BYTE_W-1:0]   wr_be,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      init_busy,
    output logic                      addr_err
);
    localparam int NB = WIDTH / BYTE_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // One extra bit so DEPTH == 2**ADDR_W is representable and no address ever wraps.
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              rd_vld1_q;
    logic [WIDTH-1:0]  rd_dat1_q;
    logic              addr_err_q, addr_err_d;

    logic              run;
    logic              wr_inr, rd_inr;
    logic              wr_ok, rd_req;
    logic [WIDTH-1:0]  rd_word;

    assign run    = (state_q == ST_RUN);
    assign wr_inr = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_inr = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_ok  = run & wr_en & wr_inr;
    assign rd_req = run & rd_en;

    // Write and read errors in the same cycle fold into a single pulse.
    assign addr_err_d = run & ((wr_en & ~wr_inr) | (rd_en & ~rd_inr));

    // Clear sequencer: one entry per cycle, then parks in RUN until the next reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            if (ptr_q == PTR_LAST) begin
                state_d = ST_RUN;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Read word before the write lands (read-first); write-first mode patches in
    // the enabled lanes of a same-address write. Out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (rd_inr) begin
            rd_word = mem_q[rd_addr];
            if ((RD_MODE == 1) && wr_ok && (wr_addr == rd_addr)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) begin
                        rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // Storage has no reset; the clear sequencer guarantees defined contents.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            rd_vld1_q  <= 1'b0;
            rd_dat1_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_vld1_q  <= rd_req;
            addr_err_q <= addr_err_d;
            if (rd_req) begin
                rd_dat1_q <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             rd_vld2_q;
            logic [WIDTH-1:0] rd_dat2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_vld2_q <= 1'b0;
                    rd_dat2_q <= '0;
                end else begin
                    rd_vld2_q <= rd_vld1_q;
                    if (rd_vld1_q) begin
                        rd_dat2_q <= rd_dat1_q;
                    end
                end
            end

            assign rd_valid = rd_vld2_q;
            assign rd_data  = rd_dat2_q;
        end else begin : g_no_out_reg
            assign rd_valid = rd_vld1_q;
            assign rd_data  = rd_dat1_q;
        end
    endgenerate

    assign init_busy = (state_q == ST_INIT);
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_param_memory_2p.sv
// Directed bench for param_memory_2p with two instances on shared stimulus:
// u_a: DEPTH=256, read-first, output register (latency 2);
// u_b: DEPTH=200, write-first, no output register (latency 1).
module tb_param_memory_2p;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [7:0]  rd_addr;

    logic [31:0] a_rd_data, b_rd_data;
    logic        a_rd_valid, b_rd_valid;
    logic        a_init_busy, b_init_busy;
    logic        a_addr_err, b_addr_err;

    int errors = 0;
    int checks = 0;

    param_memory_2p #(.WIDTH(32), .DEPTH(256), .ADDR_W(8), .BYTE_W(8), .RD_MODE(0), .OUT_REG(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .init_busy(a_init_busy), .addr_err(a_addr_err)
    );

    param_memory_2p #(.WIDTH(32), .DEPTH(200), .ADDR_W(8), .BYTE_W(8), .RD_MODE(1), .OUT_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .init_busy(b_init_busy), .addr_err(b_addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    // Single read: u_b answers after one edge, u_a after two.
    task automatic rd_check(input string tag, input logic [7:0] a,
                            input logic [31:0] exp_a, input logic [31:0] exp_b);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_b"}, {b_rd_valid, b_rd_data}, {1'b1, exp_b});
        tick();
        chk({tag, "_a"}, {a_rd_valid, a_rd_data}, {1'b1, exp_a});
    endtask

    task automatic count_init(input string tag);
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 199) chk({tag, "_b_busy199"}, b_init_busy, 1'b1);
            if (k == 200) chk({tag, "_b_busy200"}, b_init_busy, 1'b0);
            if (k == 255) chk({tag, "_a_busy255"}, a_init_busy, 1'b1);
            if (k == 256) chk({tag, "_a_busy256"}, a_init_busy, 1'b0);
        end
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_a", {a_init_busy, a_rd_valid, a_addr_err, a_rd_data}, {1'b1, 1'b0, 1'b0, 32'h0});
        chk("rst_b", {b_init_busy, b_rd_valid, b_addr_err, b_rd_data}, {1'b1, 1'b0, 1'b0, 32'h0});

        // Clear sequence with requests presented during INIT (must be ignored)
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            if (k <= 150) begin
                wr_en = 1'b1; wr_addr = 8'd3; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
                rd_en = 1'b1; rd_addr = 8'd250;
            end else begin
                idle();
            end
            tick();
            seen = seen | a_rd_valid | b_rd_valid | a_addr_err | b_addr_err;
            if (k == 199) chk("init_b_busy199", b_init_busy, 1'b1);
            if (k == 200) chk("init_b_busy200", b_init_busy, 1'b0);
            if (k == 255) chk("init_a_busy255", a_init_busy, 1'b1);
            if (k == 256) chk("init_a_busy256", a_init_busy, 1'b0);
        end
        chk("init_requests_dropped", seen, 1'b0);

        // Back-to-back scan of every entry: all zero, one result per cycle
        for (int i = 0; i < 258; i++) begin
            if (i < 256) begin
                rd_en = 1'b1; rd_addr = 8'(i);
            end else begin
                rd_en = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 256) chk("scan_zero", {a_rd_valid, a_rd_data}, {1'b1, 32'h0});
            if (i == 257) chk("scan_drain", a_rd_valid, 1'b0);
        end

        // Full write then read, checking exact latency on u_a
        wr(8'd5, 32'hDEAD_BEEF, 4'hF);
        rd_en = 1'b1; rd_addr = 8'd5;
        tick();
        rd_en = 1'b0;
        chk("lat_a_not_yet", a_rd_valid, 1'b0);
        chk("lat_b_1cyc", {b_rd_valid, b_rd_data}, {1'b1, 32'hDEAD_BEEF});
        tick();
        chk("lat_a_2cyc", {a_rd_valid, a_rd_data}, {1'b1, 32'hDEAD_BEEF});
        chk("strobe_b_off", b_rd_valid, 1'b0);
        tick();
        chk("strobe_a_off", a_rd_valid, 1'b0);

        // Byte-enable merge and zero-enable write
        wr(8'd7, 32'h1122_3344, 4'hF);
        wr(8'd7, 32'hAABB_CCDD, 4'b0101);
        rd_check("be_merge", 8'd7, 32'h11BB_33DD, 32'h11BB_33DD);
        wr(8'd7, 32'hFFFF_FFFF, 4'h0);
        rd_check("be_none", 8'd7, 32'h11BB_33DD, 32'h11BB_33DD);
        tick();
        chk("hold_a", {a_rd_valid, a_rd_data}, {1'b0, 32'h11BB_33DD});
        chk("hold_b", {b_rd_valid, b_rd_data}, {1'b0, 32'h11BB_33DD});

        // Same-address collision, full word
        wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'h55; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'd9;
        tick();
        idle();
        chk("coll_b_wfirst", {b_rd_valid, b_rd_data}, {1'b1, 32'h55});
        tick();
        chk("coll_a_rfirst", {a_rd_valid, a_rd_data}, {1'b1, 32'h0});
        rd_check("coll_after", 8'd9, 32'h55, 32'h55);

        // Same-address collision, partial lanes
        wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'hAABB_CCDD; wr_be = 4'b0011;
        rd_en = 1'b1; rd_addr = 8'd9;
        tick();
        idle();
        chk("pcoll_b", {b_rd_valid, b_rd_data}, {1'b1, 32'h0000_CCDD});
        tick();
        chk("pcoll_a", {a_rd_valid, a_rd_data}, {1'b1, 32'h0000_0055});
        rd_check("pcoll_after", 8'd9, 32'h0000_CCDD, 32'h0000_CCDD);

        // Out-of-range on u_b (DEPTH=200); address 250 is in range for u_a
        wr_en = 1'b1; wr_addr = 8'd250; wr_data = 32'h1234_5678; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'd250;
        tick();
        idle();
        chk("oor_b_err", b_addr_err, 1'b1);
        chk("oor_b_rd", {b_rd_valid, b_rd_data}, {1'b1, 32'h0});
        chk("oor_a_noerr", a_addr_err, 1'b0);
        tick();
        chk("oor_b_single_pulse", b_addr_err, 1'b0);
        chk("oor_a_rd", {a_rd_valid, a_rd_data}, {1'b1, 32'h0});
        rd_check("oor_wr_a_lands", 8'd250, 32'h1234_5678, 32'h0);
        rd_check("oor_no_wrap", 8'd50, 32'h0, 32'h0);
        wr_en = 1'b1; wr_addr = 8'd201; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
        tick();
        idle();
        chk("oor_wr_only_err", b_addr_err, 1'b1);
        tick();
        chk("oor_wr_only_end", b_addr_err, 1'b0);

        // Reset in the middle of a read burst
        rd_en = 1'b1; rd_addr = 8'd5;
        tick();
        rd_addr = 8'd7;
        tick();
        chk("burst_a_pre", {a_rd_valid, a_rd_data}, {1'b1, 32'hDEAD_BEEF});
        #2 rst_n = 1'b0;
        #1;
        idle();
        chk("midrst_a", {a_init_busy, a_rd_valid, a_addr_err, a_rd_data}, {1'b1, 1'b0, 1'b0, 32'h0});
        chk("midrst_b", {b_init_busy, b_rd_valid, b_addr_err, b_rd_data}, {1'b1, 1'b0, 1'b0, 32'h0});
        tick();
        tick();
        rst_n = 1'b1;

        // Reset again at INIT cycle 100; clear must restart and take a full DEPTH cycles
        repeat (100) tick();
        chk("init100_busy", a_init_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("init100_rst_busy", {a_init_busy, b_init_busy}, 2'b11);
        tick();
        rst_n = 1'b1;
        count_init("reinit");

        // Clear after reset wiped previously written data
        rd_check("cleared5", 8'd5, 32'h0, 32'h0);
        rd_check("cleared7", 8'd7, 32'h0, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
